// File: rtl/axi_regfile_slave_if.sv
// AR/R/AW/W/B channel bundle between an AXI-lite-style master and the register file responder.
interface axi_regfile_slave_if;
  logic [3:0] read_address;
  logic       AR_VALID;
  logic       AR_READY;
  logic [7:0] data_read;
  logic [3:0] RRESPONSE;
  logic       R_VALID;
  logic       R_READY;
  logic [3:0] write_address;
  logic       AW_VALID;
  logic       AW_READY;
  logic [7:0] write_data;
  logic       W_VALID;
  logic       W_READY;
  logic       B_VALID;
  logic [3:0] BRESPONSE;
  logic       B_READY;

  modport slave (
    input  read_address, AR_VALID, R_READY, write_address, AW_VALID, write_data, W_VALID, B_READY,
    output AR_READY, data_read, RRESPONSE, R_VALID, AW_READY, W_READY, B_VALID, BRESPONSE
  );

  modport master (
    output read_address, AR_VALID, R_READY, write_address, AW_VALID, write_data, W_VALID, B_READY,
    input  AR_READY, data_read, RRESPONSE, R_VALID, AW_READY, W_READY, B_VALID, BRESPONSE
  );
endinterface

// File: rtl/axi_regfile_slave.sv
// AXI-lite-style responder for a small 8-bit register file: address 0 is a read-only ID,
// one outstanding read and one outstanding write, AW and W accepted independently.
module axi_regfile_slave #(
  parameter int unsigned NUM_REGS    = 12,
  parameter logic [7:0]  ID_VALUE    = 8'hA5,
  parameter logic [7:0]  RESET_VALUE = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_regfile_slave_if.slave bus
);

  localparam logic [4:0] LP_NUM_REGS = 5'(NUM_REGS);
  localparam logic [3:0] LP_OKAY     = 4'h0;
  localparam logic [3:0] LP_SLVERR   = 4'h2;

  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  rstate_t    r_rstate, w_rstate_nxt;
  logic [7:0] r_regs [16];
  logic [7:0] r_rdata;
  logic [3:0] r_rresp;
  logic       r_aw_held, r_w_held, r_b_valid;
  logic [3:0] r_aw_addr;
  logic [7:0] r_w_data;
  logic [3:0] r_bresp;

  logic       w_ar_hs, w_rd_err, w_commit, w_wr_ok;
  logic [7:0] w_rd_val;

  // ---------------- read path ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      R_IDLE: if (bus.AR_VALID) w_rstate_nxt = R_DATA;
      R_DATA: if (bus.R_READY)  w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_ar_hs = (r_rstate == R_IDLE) && bus.AR_VALID;

  always_comb begin
    w_rd_err = 1'b0;
    w_rd_val = '0;
    if (bus.read_address == 4'd0)
      w_rd_val = ID_VALUE;
    else if ({1'b0, bus.read_address} < LP_NUM_REGS)
      w_rd_val = r_regs[bus.read_address];
    else
      w_rd_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_rresp <= '0;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_val;
      r_rresp <= w_rd_err ? LP_SLVERR : LP_OKAY;
    end
  end

  assign bus.AR_READY  = (r_rstate == R_IDLE);
  assign bus.R_VALID   = (r_rstate == R_DATA);
  assign bus.data_read = r_rdata;
  assign bus.RRESPONSE = r_rresp;

  // ---------------- write path ----------------
  assign w_commit = r_aw_held && r_w_held && !r_b_valid;
  assign w_wr_ok  = (r_aw_addr != 4'd0) && ({1'b0, r_aw_addr} < LP_NUM_REGS);

  // Held flags are released by the B handshake rather than the commit, so AW/W stay
  // back-pressured while the response is outstanding without any extra state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_b_valid <= 1'b0;
      r_bresp   <= '0;
      for (int unsigned i = 0; i < 16; i++) r_regs[i] <= RESET_VALUE;
    end else begin
      if (!r_aw_held && bus.AW_VALID) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= bus.write_address;
      end
      if (!r_w_held && bus.W_VALID) begin
        r_w_held <= 1'b1;
        r_w_data <= bus.write_data;
      end
      if (r_b_valid && bus.B_READY) begin
        r_b_valid <= 1'b0;
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else if (w_commit) begin
        r_b_valid <= 1'b1;
        r_bresp   <= w_wr_ok ? LP_OKAY : LP_SLVERR;
        if (w_wr_ok) r_regs[r_aw_addr] <= r_w_data;
      end
    end
  end

  assign bus.AW_READY  = !r_aw_held;
  assign bus.W_READY   = !r_w_held;
  assign bus.B_VALID   = r_b_valid;
  assign bus.BRESPONSE = r_bresp;

endmodule

// File: tb/tb_axi_regfile_slave.sv
// Directed self-checking bench for axi_regfile_slave; inputs driven and outputs sampled on negedge.
module tb_axi_regfile_slave;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_regfile_slave_if bus ();

  axi_regfile_slave #(
    .NUM_REGS   (12),
    .ID_VALUE   (8'hA5),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Full write transaction with B_READY held high; starts and ends on a negedge.
  task automatic axi_write(input logic [3:0] a, input logic [7:0] d, output logic [3:0] resp, output bit ok);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs, got = 0;
    resp = 'x;
    bus.write_address = a; bus.write_data = d;
    bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      aw_hs = bus.AW_VALID && bus.AW_READY;
      w_hs  = bus.W_VALID && bus.W_READY;
      @(negedge clk);
      if (aw_hs) begin bus.AW_VALID = 1'b0; aw_done = 1; end
      if (w_hs)  begin bus.W_VALID  = 1'b0; w_done  = 1; end
    end
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    bus.B_READY = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      if (bus.B_VALID) begin resp = bus.BRESPONSE; got = 1; end
      @(negedge clk);
    end
    bus.B_READY = 1'b0;
    ok = aw_done && w_done && got;
  endtask

  // Full read transaction with R_READY held high; starts and ends on a negedge.
  task automatic axi_read(input logic [3:0] a, output logic [7:0] d, output logic [3:0] resp, output bit ok);
    bit ar_done = 0, ar_hs, got = 0;
    d = 'x; resp = 'x;
    bus.read_address = a; bus.AR_VALID = 1'b1; bus.R_READY = 1'b1;
    for (int n = 0; n < 20 && !ar_done; n++) begin
      ar_hs = bus.AR_VALID && bus.AR_READY;
      if (ar_hs) begin
        @(negedge clk);
        bus.AR_VALID = 1'b0; ar_done = 1;
      end else @(negedge clk);
    end
    bus.AR_VALID = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (bus.R_VALID) begin d = bus.data_read; resp = bus.RRESPONSE; got = 1; end
      @(negedge clk);
    end
    bus.R_READY = 1'b0;
    ok = ar_done && got;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++; if (bus.R_VALID !== 1'b0)   begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", bus.R_VALID); end
    n_checks++; if (bus.B_VALID !== 1'b0)   begin n_fail++; $display("FAIL rst_bvalid: got %b want 0", bus.B_VALID); end
    n_checks++; if (bus.AR_READY !== 1'b1)  begin n_fail++; $display("FAIL rst_arready: got %b want 1", bus.AR_READY); end
    n_checks++; if ({bus.AW_READY, bus.W_READY} !== 2'b11) begin n_fail++; $display("FAIL rst_awwready: got %b want 11", {bus.AW_READY, bus.W_READY}); end
    n_checks++; if ({bus.data_read, bus.RRESPONSE, bus.BRESPONSE} !== 16'h0000) begin n_fail++; $display("FAIL rst_data_resp: got %h want 0000", {bus.data_read, bus.RRESPONSE, bus.BRESPONSE}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_write_read;
    bus.write_address = 4'h6; bus.write_data = 8'hAA;
    bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1; bus.B_READY = 1'b1;
    @(negedge clk);
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    n_checks++; if (bus.B_VALID !== 1'b0) begin n_fail++; $display("FAIL t1_b_early: got %b want 0", bus.B_VALID); end
    @(negedge clk);
    n_checks++; if (bus.B_VALID !== 1'b1) begin n_fail++; $display("FAIL t1_b_latency: got %b want 1", bus.B_VALID); end
    n_checks++; if (bus.BRESPONSE !== 4'h0) begin n_fail++; $display("FAIL t1_bresp: got %h want 0", bus.BRESPONSE); end
    @(negedge clk);
    bus.B_READY = 1'b0;
    n_checks++; if (bus.B_VALID !== 1'b0) begin n_fail++; $display("FAIL t1_b_clear: got %b want 0", bus.B_VALID); end
    bus.read_address = 4'h6; bus.AR_VALID = 1'b1; bus.R_READY = 1'b1;
    @(negedge clk);
    bus.AR_VALID = 1'b0;
    n_checks++; if ({bus.R_VALID, bus.data_read, bus.RRESPONSE} !== {1'b1, 8'hAA, 4'h0}) begin n_fail++; $display("FAIL t1_read: got %b/%h/%h want 1/aa/0", bus.R_VALID, bus.data_read, bus.RRESPONSE); end
    @(negedge clk);
    bus.R_READY = 1'b0;
    n_checks++; if (bus.R_VALID !== 1'b0) begin n_fail++; $display("FAIL t1_r_clear: got %b want 0", bus.R_VALID); end
  endtask

  task automatic test_w_before_aw;
    logic [7:0] d; logic [3:0] rs; bit ok;
    bus.write_data = 8'h3C; bus.W_VALID = 1'b1;
    @(negedge clk);
    bus.W_VALID = 1'b0;
    n_checks++; if (bus.W_READY !== 1'b0) begin n_fail++; $display("FAIL t2_wready_held: got %b want 0", bus.W_READY); end
    repeat (2) @(negedge clk);
    n_checks++; if ({bus.W_READY, bus.B_VALID} !== 2'b00) begin n_fail++; $display("FAIL t2_wait: got %b want 00", {bus.W_READY, bus.B_VALID}); end
    bus.write_address = 4'h2; bus.AW_VALID = 1'b1; bus.B_READY = 1'b1;
    @(negedge clk);
    bus.AW_VALID = 1'b0;
    n_checks++; if (bus.B_VALID !== 1'b0) begin n_fail++; $display("FAIL t2_b_early: got %b want 0", bus.B_VALID); end
    @(negedge clk);
    n_checks++; if ({bus.B_VALID, bus.BRESPONSE, bus.W_READY} !== {1'b1, 4'h0, 1'b0}) begin n_fail++; $display("FAIL t2_b: got %b/%h/%b want 1/0/0", bus.B_VALID, bus.BRESPONSE, bus.W_READY); end
    @(negedge clk);
    bus.B_READY = 1'b0;
    n_checks++; if (bus.W_READY !== 1'b1) begin n_fail++; $display("FAIL t2_wready_free: got %b want 1", bus.W_READY); end
    axi_read(4'h2, d, rs, ok);
    n_checks++; if ({ok, d, rs} !== {1'b1, 8'h3C, 4'h0}) begin n_fail++; $display("FAIL t2_readback: got %b/%h/%h want 1/3c/0", ok, d, rs); end
  endtask

  task automatic test_b_backpressure;
    logic [7:0] d; logic [3:0] rs; bit ok;
    bus.write_address = 4'h5; bus.write_data = 8'h99;
    bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1; bus.B_READY = 1'b0;
    @(negedge clk);
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bus.B_VALID, bus.BRESPONSE, bus.AW_READY, bus.W_READY} !== {1'b1, 4'h0, 2'b00}) begin
        n_fail++; $display("FAIL t3_stall[%0d]: got %b/%h/%b%b want 1/0/00", i, bus.B_VALID, bus.BRESPONSE, bus.AW_READY, bus.W_READY);
      end
      @(negedge clk);
    end
    bus.B_READY = 1'b1;
    @(negedge clk);
    bus.B_READY = 1'b0;
    n_checks++; if ({bus.B_VALID, bus.AW_READY} !== 2'b01) begin n_fail++; $display("FAIL t3_release: got %b want 01", {bus.B_VALID, bus.AW_READY}); end
    axi_write(4'h4, 8'h11, rs, ok);
    n_checks++; if ({ok, rs} !== {1'b1, 4'h0}) begin n_fail++; $display("FAIL t3_second_write: got %b/%h want 1/0", ok, rs); end
    axi_read(4'h4, d, rs, ok);
    n_checks++; if ({ok, d, rs} !== {1'b1, 8'h11, 4'h0}) begin n_fail++; $display("FAIL t3_readback: got %b/%h/%h want 1/11/0", ok, d, rs); end
    axi_read(4'h5, d, rs, ok);
    n_checks++; if ({ok, d, rs} !== {1'b1, 8'h99, 4'h0}) begin n_fail++; $display("FAIL t3_readback5: got %b/%h/%h want 1/99/0", ok, d, rs); end
  endtask

  task automatic test_errors;
    logic [7:0] d; logic [3:0] rs; bit ok;
    axi_write(4'hD, 8'h55, rs, ok);
    n_checks++; if ({ok, rs} !== {1'b1, 4'h2}) begin n_fail++; $display("FAIL t4_wr_oob: got %b/%h want 1/2", ok, rs); end
    axi_read(4'hD, d, rs, ok);
    n_checks++; if ({ok, d, rs} !== {1'b1, 8'h00, 4'h2}) begin n_fail++; $display("FAIL t4_rd_oob: got %b/%h/%h want 1/00/2", ok, d, rs); end
    axi_write(4'h0, 8'h00, rs, ok);
    n_checks++; if ({ok, rs} !== {1'b1, 4'h2}) begin n_fail++; $display("FAIL t4_wr_id: got %b/%h want 1/2", ok, rs); end
    axi_read(4'h0, d, rs, ok);
    n_checks++; if ({ok, d, rs} !== {1'b1, 8'hA5, 4'h0}) begin n_fail++; $display("FAIL t4_rd_id: got %b/%h/%h want 1/a5/0", ok, d, rs); end
    axi_write(4'hB, 8'h3E, rs, ok);
    n_checks++; if ({ok, rs} !== {1'b1, 4'h0}) begin n_fail++; $display("FAIL t4_wr_last: got %b/%h want 1/0", ok, rs); end
    axi_read(4'hB, d, rs, ok);
    n_checks++; if ({ok, d, rs} !== {1'b1, 8'h3E, 4'h0}) begin n_fail++; $display("FAIL t4_rd_last: got %b/%h/%h want 1/3e/0", ok, d, rs); end
    axi_read(4'hC, d, rs, ok);
    n_checks++; if ({ok, d, rs} !== {1'b1, 8'h00, 4'h2}) begin n_fail++; $display("FAIL t4_rd_first_oob: got %b/%h/%h want 1/00/2", ok, d, rs); end
  endtask

  task automatic test_r_backpressure_and_collision;
    logic [7:0] d; logic [3:0] rs; bit ok;
    bus.read_address = 4'h6; bus.AR_VALID = 1'b1; bus.R_READY = 1'b0;
    @(negedge clk);
    bus.AR_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bus.R_VALID, bus.data_read, bus.AR_READY} !== {1'b1, 8'hAA, 1'b0}) begin
        n_fail++; $display("FAIL t5_stall[%0d]: got %b/%h/%b want 1/aa/0", i, bus.R_VALID, bus.data_read, bus.AR_READY);
      end
      @(negedge clk);
    end
    bus.R_READY = 1'b1;
    @(negedge clk);
    bus.R_READY = 1'b0;
    n_checks++; if ({bus.R_VALID, bus.AR_READY} !== 2'b01) begin n_fail++; $display("FAIL t5_release: got %b want 01", {bus.R_VALID, bus.AR_READY}); end
    // AW/W handshake this edge; commit and AR handshake coincide on the next edge.
    bus.write_address = 4'h6; bus.write_data = 8'h77;
    bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
    @(negedge clk);
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    bus.read_address = 4'h6; bus.AR_VALID = 1'b1; bus.R_READY = 1'b1; bus.B_READY = 1'b1;
    @(negedge clk);
    bus.AR_VALID = 1'b0;
    n_checks++; if ({bus.B_VALID, bus.R_VALID, bus.data_read} !== {2'b11, 8'hAA}) begin n_fail++; $display("FAIL t5_collision_old: got %b%b/%h want 11/aa", bus.B_VALID, bus.R_VALID, bus.data_read); end
    @(negedge clk);
    bus.R_READY = 1'b0; bus.B_READY = 1'b0;
    axi_read(4'h6, d, rs, ok);
    n_checks++; if ({ok, d, rs} !== {1'b1, 8'h77, 4'h0}) begin n_fail++; $display("FAIL t5_collision_new: got %b/%h/%h want 1/77/0", ok, d, rs); end
  endtask

  task automatic test_reset_midflight;
    logic [7:0] d; logic [3:0] rs; bit ok;
    bus.write_address = 4'h6; bus.write_data = 8'h12; bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1; bus.B_READY = 1'b0;
    bus.read_address = 4'h6; bus.AR_VALID = 1'b1; bus.R_READY = 1'b0;
    @(negedge clk);
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0; bus.AR_VALID = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.B_VALID, bus.R_VALID} !== 2'b11) begin n_fail++; $display("FAIL t6_pending: got %b want 11", {bus.B_VALID, bus.R_VALID}); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.B_VALID, bus.R_VALID} !== 2'b00) begin n_fail++; $display("FAIL t6_async_drop: got %b want 00", {bus.B_VALID, bus.R_VALID}); end
    n_checks++; if ({bus.AR_READY, bus.AW_READY, bus.W_READY} !== 3'b111) begin n_fail++; $display("FAIL t6_async_ready: got %b want 111", {bus.AR_READY, bus.AW_READY, bus.W_READY}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({bus.B_VALID, bus.R_VALID} !== 2'b00) begin n_fail++; $display("FAIL t6_no_stale_resp: got %b want 00", {bus.B_VALID, bus.R_VALID}); end
    axi_read(4'h6, d, rs, ok);
    n_checks++; if ({ok, d, rs} !== {1'b1, 8'h00, 4'h0}) begin n_fail++; $display("FAIL t6_rd6: got %b/%h/%h want 1/00/0", ok, d, rs); end
    axi_read(4'h0, d, rs, ok);
    n_checks++; if ({ok, d, rs} !== {1'b1, 8'hA5, 4'h0}) begin n_fail++; $display("FAIL t6_rd0: got %b/%h/%h want 1/a5/0", ok, d, rs); end
  endtask

  initial begin
    bus.read_address = '0; bus.AR_VALID = 1'b0; bus.R_READY = 1'b0;
    bus.write_address = '0; bus.AW_VALID = 1'b0; bus.write_data = '0; bus.W_VALID = 1'b0; bus.B_READY = 1'b0;
    test_reset();
    test_basic_write_read();
    test_w_before_aw();
    test_b_backpressure();
    test_errors();
    test_r_backpressure_and_collision();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
